instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Fetch stage that executes the PC/IR commands issued by the control unit (Load_PC, Empty_PC, IRWrite).
//   Holds the PC, runs a req/ready read handshake with instruction memory, and latches the returned word into the IR.
//   Splits the IR into MIPS fields for the control unit and the register file.
// PARAMETERS
//   ADDR_W         32  PC / memory address width
//   DATA_W         32  instruction width; fixed at 32 for MIPS field split
//   RESET_VECTOR   0   PC value after Reset or Empty_PC; word-aligned
//   TIMEOUT_CYCLES 16  max FETCH cycles without Mem_Ready; used only with FETCH_TIMEOUT_EN
// PORTS
//   Clk        in  1       clock, rising edge
//   Reset      in  1       asynchronous, active-high
//   Load_PC    in  1       update PC (from control unit)
//   Empty_PC   in  1       synchronous clear of PC to RESET_VECTOR; aborts any fetch
//   IRWrite    in  1       start a fetch at the current PC
//   PC_Src     in  1       0: next PC = PC+4; 1: next PC = PC_In
//   PC_In      in  ADDR_W  jump/branch target
//   Mem_Req    out 1       read request to instruction memory
//   Mem_Addr   out ADDR_W  read address; equals PC while Mem_Req=1
//   Mem_Ready  in  1       read data valid this cycle
//   Mem_RData  in  DATA_W  read data
//   PC_Out     out ADDR_W  current PC
//   IR_Out     out DATA_W  instruction register
//   Opcode     out 6       IR[31:26]
//   Rs, Rt, Rd out 5 each  IR[25:21], IR[20:16], IR[15:11]
//   Shamt      out 5       IR[10:6]
//   Funct      out 6       IR[5:0]
//   Imm16      out 16      IR[15:0]
//   IR_Valid   out 1       IR holds the word fetched from the current PC
//   Fetch_Busy out 1       high while state=FETCH
//   Fetch_Err  out 1       sticky fetch-timeout flag
// BEHAVIOUR
//   Reset values: PC=RESET_VECTOR, IR=0, Mem_Req=0, IR_Valid=0, Fetch_Busy=0, Fetch_Err=0, state=IDLE.
//   FSM (states IDLE, FETCH, DONE):
//     IDLE -IRWrite-> FETCH
//     FETCH -Mem_Ready-> DONE; IR<=Mem_RData and IR_Valid<=1 on the same edge
//     DONE -> IDLE after 1 cycle
//   Mem_Req is registered: 1 in every FETCH cycle, 0 otherwise; no combinational path from Mem_Ready.
//   Latency: IRWrite at cycle n gives Mem_Req=1 at n+1. Mem_Ready=1 at cycle m gives new IR visible at m+1.
//     Minimum is 2 cycles (Mem_Ready in the first FETCH cycle).
//   IRWrite while in FETCH or DONE is ignored.
//   IR_Valid: cleared when entering FETCH or on any PC change; set on a completed fetch.
//   PC update rules:
//     Empty_PC has priority over Load_PC.
//     Load_PC in IDLE/DONE: PC updates on the next edge.
//     Load_PC in FETCH: the target is captured in a pending register and applied on the DONE cycle; PC never changes mid-fetch.
//     A second Load_PC while pending overwrites the pending target (last wins).
//   Empty_PC in FETCH: Mem_Req=0 next cycle, IR unchanged, IR_Valid=0, pending target dropped, state->IDLE.
//   Arithmetic: PC+4 wraps modulo 2^ADDR_W. PC_In[1:0] forced to 0 when loaded.
// CONFIGURATION
//   FETCH_TIMEOUT_EN defined:
//     Counter runs in FETCH. After TIMEOUT_CYCLES cycles with Mem_Ready=0: Mem_Req drops, state->IDLE,
//     Fetch_Err=1, IR and IR_Valid unchanged, pending Load_PC target still applied.
//     Fetch_Err is sticky; cleared only by Reset or Empty_PC.
//   FETCH_TIMEOUT_EN undefined: FETCH waits indefinitely; Fetch_Err tied 0; no counter logic.
// STRUCTURE
//   Package fetch_pkg: fetch_state_e (IDLE, FETCH, DONE); field MSB/LSB constants (OPCODE_MSB, ...); PC_STEP=4.
//   Sub-module pc_reg: PC register with clear, load, next-PC mux and deferred-load slot; instr_fetch owns FSM and IR.
// TESTING
//   Reset, then IRWrite with Mem_Ready=1 in the first FETCH cycle, Mem_RData=0x012A4020
//     -> Mem_Addr=0x0 with Mem_Req=1 for 1 cycle; IR=0x012A4020, Opcode=0, Rs=9, Rt=10, Rd=8, Funct=0x20.
//   IRWrite with Mem_Ready delayed 3 cycles
//     -> Mem_Req high 4 cycles, Fetch_Busy high 4 cycles, IR_Valid rises the cycle after Mem_Ready.
//   Load_PC, PC_Src=0 at PC=0xFFFFFFFC -> PC=0x0.
//   Load_PC, PC_Src=1, PC_In=0x00400013 -> PC=0x00400010.
//   Load_PC (PC_In=0x100) during FETCH -> Mem_Addr constant until Mem_Ready; PC=0x100 one cycle after DONE.
//   Empty_PC mid-FETCH -> Mem_Req=0 next cycle, PC=RESET_VECTOR, IR unchanged, IR_Valid=0.
//   Empty_PC and Load_PC in the same cycle -> PC=RESET_VECTOR.
//   With FETCH_TIMEOUT_EN, Mem_Ready held 0
//     -> Mem_Req drops after 16 cycles, Fetch_Err=1 and stays 1 until Empty_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage:
// FSM state encoding, MIPS field bit positions and PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter with synchronous clear, load, next-PC mux
// and a one-entry deferred-load slot used while a fetch is in flight.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              defer,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_write
);

  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pend;
  logic              pend_v;
  logic [ADDR_W-1:0] align_mask;

  assign align_mask = ~ADDR_W'(3);
  assign target = pc_src ? (pc_in & align_mask)
                         : pc + ADDR_W'(PC_STEP);

  // A direct load outside FETCH supersedes any deferred target.
  assign pc_write = clear
                  | (load & ~defer)
                  | (pend_v & ~defer);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_VECTOR;
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (clear) begin
      pc     <= RESET_VECTOR;
      pend_v <= 1'b0;
    end else if (load && defer) begin
      pend   <= target;
      pend_v <= 1'b1;
    end else if (load) begin
      pc     <= target;
      pend_v <= 1'b0;
    end else if (pend_v && !defer) begin
      pc     <= pend;
      pend_v <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, req/ready handshake to instruction memory, IR.
// Optional fetch timeout is enabled with `define FETCH_TIMEOUT_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR   = '0,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load_PC,
  input  logic              Empty_PC,
  input  logic              IRWrite,
  input  logic              PC_Src,
  input  logic [ADDR_W-1:0] PC_In,
  output logic              Mem_Req,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic              Mem_Ready,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic [ADDR_W-1:0] PC_Out,
  output logic [DATA_W-1:0] IR_Out,
  output logic [5:0]        Opcode,
  output logic [4:0]        Rs,
  output logic [4:0]        Rt,
  output logic [4:0]        Rd,
  output logic [4:0]        Shamt,
  output logic [5:0]        Funct,
  output logic [15:0]       Imm16,
  output logic              IR_Valid,
  output logic              Fetch_Busy,
  output logic              Fetch_Err
);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic              ir_load;
  logic              timeout;
  logic              pc_write;
  logic              fetch_start;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              mem_req;

  pc_reg #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk      (Clk),
    .rst      (Reset),
    .clear    (Empty_PC),
    .load     (Load_PC),
    .defer    (state == FETCH),
    .pc_src   (PC_Src),
    .pc_in    (PC_In),
    .pc       (pc),
    .pc_write (pc_write)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    unique case (state)
      IDLE: if (IRWrite) state_nxt = FETCH;
      FETCH: begin
        if (Mem_Ready) begin
          state_nxt = DONE;
          ir_load   = 1'b1;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Empty_PC) begin
      state_nxt = IDLE;
      ir_load   = 1'b0;
    end
  end

  assign fetch_start = (state != FETCH)
                     && (state_nxt == FETCH);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_req  <= 1'b0;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      mem_req <= (state_nxt == FETCH);
      if (ir_load) begin
        ir       <= Mem_RData;
        ir_valid <= 1'b1;
      end else if (pc_write || fetch_start) begin
        ir_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             fetch_err;

  assign timeout = (state == FETCH) && !Mem_Ready
                && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (Empty_PC)     fetch_err <= 1'b0;
      else if (timeout) fetch_err <= 1'b1;
      if (state != FETCH)  to_cnt <= '0;
      else if (!Mem_Ready) to_cnt <= to_cnt + 1'b1;
    end
  end

  assign Fetch_Err = fetch_err;
`else
  assign timeout   = 1'b0;
  assign Fetch_Err = 1'b0;
`endif

  assign Mem_Req    = mem_req;
  assign Mem_Addr   = pc;
  assign PC_Out     = pc;
  assign IR_Out     = ir;
  assign IR_Valid   = ir_valid;
  assign Fetch_Busy = (state == FETCH);

  assign Opcode = ir[OPCODE_MSB:OPCODE_LSB];
  assign Rs     = ir[RS_MSB:RS_LSB];
  assign Rt     = ir[RT_MSB:RT_LSB];
  assign Rd     = ir[RD_MSB:RD_LSB];
  assign Shamt  = ir[SHAMT_MSB:SHAMT_LSB];
  assign Funct  = ir[FUNCT_MSB:FUNCT_LSB];
  assign Imm16  = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, stall/timeout
// sequence, and randomized run against a transaction-level model.
module tb_instr_fetch;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld, emp, irw, src, rdy;
  logic [31:0] pcin, rdata;
  logic        req, busy, irv, err;
  logic [31:0] addr, pc, ir;
  logic [5:0]  opc, fun;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .Clk        (clk),
    .Reset      (rst),
    .Load_PC    (ld),
    .Empty_PC   (emp),
    .IRWrite    (irw),
    .PC_Src     (src),
    .PC_In      (pcin),
    .Mem_Req    (req),
    .Mem_Addr   (addr),
    .Mem_Ready  (rdy),
    .Mem_RData  (rdata),
    .PC_Out     (pc),
    .IR_Out     (ir),
    .Opcode     (opc),
    .Rs         (rs),
    .Rt         (rt),
    .Rd         (rd),
    .Shamt      (sh),
    .Funct      (fun),
    .Imm16      (imm),
    .IR_Valid   (irv),
    .Fetch_Busy (busy),
    .Fetch_Err  (err)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(logic i_irw, logic i_ld,
                        logic i_emp, logic i_src,
                        logic [31:0] i_pcin, logic i_rdy,
                        logic [31:0] i_rdata);
    irw = i_irw; ld = i_ld; emp = i_emp; src = i_src;
    pcin = i_pcin; rdy = i_rdy; rdata = i_rdata;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_irv", {31'd0, irv}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_err", {31'd0, err}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_fields(string t, logic [31:0] w);
    chk({t, "_opcode"}, {26'd0, opc}, {26'd0, w[31:26]});
    chk({t, "_rs"},     {27'd0, rs},  {27'd0, w[25:21]});
    chk({t, "_rt"},     {27'd0, rt},  {27'd0, w[20:16]});
    chk({t, "_rd"},     {27'd0, rd},  {27'd0, w[15:11]});
    chk({t, "_shamt"},  {27'd0, sh},  {27'd0, w[10:6]});
    chk({t, "_funct"},  {26'd0, fun}, {26'd0, w[5:0]});
    chk({t, "_imm"},    {16'd0, imm}, {16'd0, w[15:0]});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        irw, ld, emp, src;
    logic [31:0] pcin;
    logic        rdy;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] pc, ir;
    logic        irv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic a_irw, logic a_ld, logic a_emp, logic a_src,
    logic [31:0] a_pcin, logic a_rdy, logic [31:0] a_rd,
    logic e_req, logic [31:0] e_pc, logic [31:0] e_ir,
    logic e_irv);
    vec_t v;
    v.irw = a_irw; v.ld = a_ld; v.emp = a_emp;
    v.src = a_src; v.pcin = a_pcin; v.rdy = a_rdy;
    v.rdata = a_rd; v.req = e_req; v.pc = e_pc;
    v.ir = e_ir; v.irv = e_irv;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_ir;
  bit          m_irv, m_err, m_done;
  int          m_age;
  logic [31:0] m_pend[$];
  bit          to_en;

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_irv = 0; m_err = 0;
    m_done = 0; m_age = -1; m_pend.delete();
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit          was_done;
    tgt = src ? (pcin & 32'hFFFF_FFFC) : m_pc + 32'd4;
    if (emp) begin
      m_pc = 0; m_irv = 0; m_err = 0;
      m_age = -1; m_done = 0; m_pend.delete();
    end else if (m_age >= 0) begin
      if (ld) begin
        m_pend.delete();
        m_pend.push_back(tgt);
      end
      if (rdy) begin
        m_ir = rdata; m_irv = 1;
        m_age = -1; m_done = 1;
      end else if (to_en && m_age + 1 == TO) begin
        m_age = -1; m_err = 1;
      end else begin
        m_age++;
      end
    end else begin
      was_done = m_done;
      m_done = 0;
      if (ld) begin
        m_pc = tgt; m_irv = 0; m_pend.delete();
      end else if (m_pend.size() > 0) begin
        m_pc = m_pend.pop_front(); m_irv = 0;
      end
      if (!was_done && irw) begin
        m_age = 0; m_irv = 0;
      end
    end
  endtask

  task automatic model_cmp();
    logic f;
    f = (m_age >= 0);
    chk("m_req", {31'd0, req}, {31'd0, f});
    chk("m_busy", {31'd0, busy}, {31'd0, f});
    chk("m_pc", pc, m_pc);
    if (req) chk("m_addr", addr, m_pc);
    chk("m_ir", ir, m_ir);
    chk("m_irv", {31'd0, irv}, {31'd0, m_irv});
    chk("m_err", {31'd0, err}, {31'd0, m_err});
    chk_fields("m", m_ir);
  endtask

  initial begin
    int n;
`ifdef FETCH_TIMEOUT_EN
    to_en = 1;
`else
    to_en = 0;
`endif
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,32'h012A4020,
                     1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,
                     0,0,32'h012A4020,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,
                     0,0,32'h012A4020,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     1,0,32'h012A4020,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     1,0,32'h012A4020,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     1,0,32'h012A4020,0));
    tbl.push_back(mk(0,0,0,0,0,1,32'h8C430004,
                     1,0,32'h012A4020,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     0,0,32'h8C430004,1));
    tbl.push_back(mk(0,1,0,1,32'hFFFFFFFC,0,0,
                     0,0,32'h8C430004,1));
    tbl.push_back(mk(0,1,0,0,0,0,0,
                     0,32'hFFFFFFFC,32'h8C430004,0));
    tbl.push_back(mk(0,1,0,1,32'h00400013,0,0,
                     0,0,32'h8C430004,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     0,32'h00400010,32'h8C430004,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,
                     0,32'h00400010,32'h8C430004,0));
    tbl.push_back(mk(0,1,0,1,32'h100,0,0,
                     1,32'h00400010,32'h8C430004,0));
    tbl.push_back(mk(0,0,0,0,0,1,32'h20080005,
                     1,32'h00400010,32'h8C430004,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     0,32'h00400010,32'h20080005,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     0,32'h100,32'h20080005,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,
                     0,32'h100,32'h20080005,0));
    tbl.push_back(mk(0,0,1,0,0,0,0,
                     1,32'h100,32'h20080005,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     0,0,32'h20080005,0));
    tbl.push_back(mk(0,1,1,1,32'h40,0,0,
                     0,0,32'h20080005,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     0,0,32'h20080005,0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].irw, tbl[i].ld, tbl[i].emp,
             tbl[i].src, tbl[i].pcin, tbl[i].rdy,
             tbl[i].rdata);
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'd0, req},
          {31'd0, tbl[i].req});
      chk($sformatf("v%0d_busy", i), {31'd0, busy},
          {31'd0, tbl[i].req});
      chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      if (tbl[i].req)
        chk($sformatf("v%0d_addr", i), addr, tbl[i].pc);
      chk($sformatf("v%0d_ir", i), ir, tbl[i].ir);
      chk($sformatf("v%0d_irv", i), {31'd0, irv},
          {31'd0, tbl[i].irv});
      chk($sformatf("v%0d_err", i), {31'd0, err}, 0);
      chk_fields($sformatf("v%0d", i), tbl[i].ir);
      @(posedge clk);
      #1;
    end

    // Long stall: waits forever, or times out when enabled.
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 irw = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req) n++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("stall_ir", ir, 0);
    chk("stall_irv", {31'd0, irv}, 0);
    if (to_en) begin
      chk("to_req_cycles", n, TO);
      chk("to_err", {31'd0, err}, 1);
      chk("to_req_off", {31'd0, req}, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("to_err_sticky", {31'd0, err}, 1);
    end else begin
      chk("stall_req_cycles", n, 40);
      chk("stall_err", {31'd0, err}, 0);
    end
    @(posedge clk);
    #1 emp = 1'b1;
    @(posedge clk);
    #1 emp = 1'b0;
    @(negedge clk);
    chk("empty_err", {31'd0, err}, 0);
    chk("empty_req", {31'd0, req}, 0);
    chk("empty_pc", pc, 0);

    // Randomized run against the model.
    @(posedge clk);
    #1;
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      set_in(($urandom % 3) == 0,
             ($urandom % 7) == 0,
             ($urandom % 40) == 0,
             1'($urandom % 2),
             $urandom,
             (c % 160 < 25) ? 1'b0 : (($urandom % 3) == 0),
             $urandom);
      @(negedge clk);
      model_cmp();
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
